// File: rtl/serial_in_parallel_out_dynamic.sv
// Serial-to-parallel packet assembler with per-packet length (1..max_els_p words).
// Words are collected into element registers and presented together on data_o until the consumer takes them.
module serial_in_parallel_out_dynamic #(
    parameter int unsigned width_p       = 64,
    parameter int unsigned max_els_p     = 8,
    localparam int unsigned lg_max_els_lp = (max_els_p > 1) ? $clog2(max_els_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    input  logic [width_p-1:0]             data_i,
    input  logic [lg_max_els_lp-1:0]       len_i,
    output logic                           ready_o,
    output logic                           len_ready_o,
    output logic                           v_o,
    output logic [max_els_p*width_p-1:0]   data_o,
    input  logic                           yumi_i
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    state_e                               state_q;
    state_e                               state_d;
    logic [lg_max_els_lp-1:0]             cnt_q;
    logic [lg_max_els_lp-1:0]             len_q;
    logic                                 len_v_q;
    logic [lg_max_els_lp-1:0]             len_sat;
    logic [lg_max_els_lp-1:0]             cur_len;
    logic                                 accept;
    logic                                 last_word;
    logic [max_els_p-1:0][width_p-1:0]    els_q;

    // Clamp the requested length so the counter never walks past the last element
    always_comb begin
        len_sat = len_i;
        if (32'(len_i) > (max_els_p - 1)) begin
            len_sat = lg_max_els_lp'(max_els_p - 1);
        end
    end

    // The first word of a packet uses the live length; later words use the latched one
    assign cur_len   = (len_v_q && (cnt_q != '0)) ? len_q : len_sat;
    assign accept    = v_i & ready_o;
    assign last_word = accept && (cnt_q == cur_len);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (last_word) state_d = FULL;
            FULL:    if (yumi_i)    state_d = COLLECT;
            default:                state_d = COLLECT;
        endcase
    end

    always_comb begin
        ready_o     = 1'b0;
        v_o         = 1'b0;
        len_ready_o = 1'b0;
        case (state_q)
            COLLECT: begin
                ready_o     = 1'b1;
                len_ready_o = (cnt_q == '0);
            end
            FULL:    v_o = 1'b1;
            default: ;
        endcase
    end

    // Word counter and one-entry length FIFO
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            len_q   <= '0;
            len_v_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= last_word ? '0 : cnt_q + lg_max_els_lp'(1);
                if (cnt_q == '0) begin
                    len_q   <= len_sat;
                    len_v_q <= 1'b1;
                end
            end
            if ((state_q == FULL) && yumi_i) begin
                len_v_q <= 1'b0;
            end
        end
    end

    // Element registers; elements beyond the packet length keep their old contents
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            els_q <= '0;
        end else begin
            for (int unsigned k = 0; k < max_els_p; k++) begin
                if (accept && (cnt_q == lg_max_els_lp'(k))) begin
                    els_q[k] <= data_i;
                end
            end
        end
    end

    assign data_o = els_q;

endmodule

// File: tb/tb_serial_in_parallel_out_dynamic.sv
// Directed bench for serial_in_parallel_out_dynamic: a cycle table on an 8x4 instance
// plus hand-written reset and length-saturation sequences (saturation on an 8x5 instance).
module tb_serial_in_parallel_out_dynamic;

    logic        clk_i = 1'b0;
    logic        reset_i;

    logic        a_v, a_yumi, a_ready, a_len_ready, a_vo;
    logic [7:0]  a_data;
    logic [1:0]  a_len;
    logic [31:0] a_out;

    logic        b_v, b_yumi, b_ready, b_len_ready, b_vo;
    logic [7:0]  b_data;
    logic [2:0]  b_len;
    logic [39:0] b_out;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    always #5 clk_i = ~clk_i;

    serial_in_parallel_out_dynamic #(.width_p(8), .max_els_p(4)) dut_a (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(a_v), .data_i(a_data), .len_i(a_len),
        .ready_o(a_ready), .len_ready_o(a_len_ready), .v_o(a_vo), .data_o(a_out),
        .yumi_i(a_yumi)
    );

    serial_in_parallel_out_dynamic #(.width_p(8), .max_els_p(5)) dut_b (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(b_v), .data_i(b_data), .len_i(b_len),
        .ready_o(b_ready), .len_ready_o(b_len_ready), .v_o(b_vo), .data_o(b_out),
        .yumi_i(b_yumi)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [1:0]  len;
        logic        y;
        logic        ev;
        logic        er;
        logic        elr;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] d, input logic [1:0] len, input logic y,
                       input logic ev, input logic er, input logic elr, input logic [31:0] ed);
        vec_t t;
        t.v = v; t.d = d; t.len = len; t.y = y;
        t.ev = ev; t.er = er; t.elr = elr; t.ed = ed;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_a(input string tag, input logic ev, input logic er, input logic elr,
                           input logic [31:0] ed);
        check({tag, " v_o"},         64'(a_vo),        64'(ev));
        check({tag, " ready_o"},     64'(a_ready),     64'(er));
        check({tag, " len_ready_o"}, 64'(a_len_ready), 64'(elr));
        check({tag, " data_o"},      64'(a_out),       64'(ed));
    endtask

    initial begin
        reset_i = 1'b1;
        a_v = 1'b0; a_data = '0; a_len = '0; a_yumi = 1'b0;
        b_v = 1'b0; b_data = '0; b_len = '0; b_yumi = 1'b0;

        // Inputs for one cycle, then outputs expected right after that edge
        //   v  data   len   yumi  ev   er   elr  data_o
        add(1, 8'h11, 2'd3, 0,   0,   1,   0,   32'h0000_0011);
        add(1, 8'h22, 2'd0, 0,   0,   1,   0,   32'h0000_2211);
        add(1, 8'h33, 2'd0, 0,   0,   1,   0,   32'h0033_2211);
        add(1, 8'h44, 2'd0, 0,   1,   0,   0,   32'h4433_2211);
        for (int i = 0; i < 5; i++)
            add(1, 8'h55 + 8'(i), 2'd0, 0, 1, 0, 0, 32'h4433_2211);
        add(0, 8'h00, 2'd0, 1,   0,   1,   1,   32'h4433_2211);
        add(1, 8'hAB, 2'd0, 1,   1,   0,   0,   32'h4433_22AB);
        add(0, 8'h00, 2'd0, 1,   0,   1,   1,   32'h4433_22AB);
        add(1, 8'h01, 2'd2, 0,   0,   1,   0,   32'h4433_2201);
        add(0, 8'h00, 2'd0, 0,   0,   1,   0,   32'h4433_2201);
        add(0, 8'h00, 2'd0, 0,   0,   1,   0,   32'h4433_2201);
        add(1, 8'h02, 2'd0, 0,   0,   1,   0,   32'h4433_0201);
        add(0, 8'h00, 2'd0, 0,   0,   1,   0,   32'h4433_0201);
        add(0, 8'h00, 2'd0, 0,   0,   1,   0,   32'h4433_0201);
        add(1, 8'h03, 2'd0, 0,   1,   0,   0,   32'h4403_0201);
        add(0, 8'h00, 2'd0, 1,   0,   1,   1,   32'h4403_0201);
        add(1, 8'h11, 2'd1, 0,   0,   1,   0,   32'h4403_0211);
        add(1, 8'h22, 2'd0, 0,   1,   0,   0,   32'h4403_2211);
        add(1, 8'h99, 2'd0, 1,   0,   1,   1,   32'h4403_2211);
        add(1, 8'h77, 2'd0, 0,   1,   0,   0,   32'h4403_2277);
        add(0, 8'h00, 2'd0, 1,   0,   1,   1,   32'h4403_2277);

        repeat (2) @(posedge clk_i);
        #1;
        check_a("reset", 1'b0, 1'b1, 1'b1, 32'h0);
        reset_i = 1'b0;

        foreach (vecs[i]) begin
            a_v = vecs[i].v; a_data = vecs[i].d; a_len = vecs[i].len; a_yumi = vecs[i].y;
            cyc();
            check_a($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].elr, vecs[i].ed);
        end
        a_v = 1'b0; a_yumi = 1'b0;

        // Reset two words into a four-word packet discards it asynchronously
        a_v = 1'b1; a_len = 2'd3; a_data = 8'hC1;
        cyc();
        a_data = 8'hC2;
        cyc();
        a_v = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        check_a("rst_mid", 1'b0, 1'b1, 1'b1, 32'h0);
        cyc();
        reset_i = 1'b0;
        a_v = 1'b1; a_len = 2'd0; a_data = 8'h5A;
        cyc();
        a_v = 1'b0;
        check_a("post_rst", 1'b1, 1'b0, 1'b0, 32'h0000_005A);

        // Reset while a packet is pending drops it
        #2 reset_i = 1'b1;
        #1;
        check_a("rst_full", 1'b0, 1'b1, 1'b1, 32'h0);
        cyc();
        reset_i = 1'b0;

        // len_i=7 on a 5-element block clamps to 4: five words complete the packet
        b_len = 3'd7;
        for (int i = 1; i <= 5; i++) begin
            b_v = 1'b1; b_data = 8'(i);
            cyc();
            if (i == 1) b_len = 3'd0;
            check($sformatf("sat word%0d v_o", i), 64'(b_vo), 64'(i == 5));
        end
        b_v = 1'b0;
        check("sat data_o", 64'(b_out), 64'h05_0403_0201);
        check("sat ready_o", 64'(b_ready), 64'h0);
        b_yumi = 1'b1;
        cyc();
        b_yumi = 1'b0;
        check("sat after yumi v_o", 64'(b_vo), 64'h0);
        check("sat after yumi len_ready_o", 64'(b_len_ready), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
